// File: rtl/spi_pkg.sv
// Shared SPI front-end definitions: default frame width,
// synchroniser depth and the sampler FSM state encoding.
package spi_pkg;

  localparam int SPI_WIDTH       = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Input synchroniser plus history flop with edge pulses.
// Ports: clk, rst_n, din -> level (synced), rise, fall pulses.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_sampler.sv
// SPI mode-1 frame sampler in the clk domain.
// Ports: clk, rst_n, sclk, cs, mosi, tx_data in; miso, rx_data,
// rx_valid, frame_err, busy out. Option: SPI_SAMPLER_MISO_EN.
module spi_sampler
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .level(sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs),
    .level(cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (mosi),
    .level(mosi_s),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  spi_state_e             state;
  logic [CW-1:0]          count;
  logic [WIDTH-1:0]       shreg;
  logic [SYNC_STAGES-1:0] prime;
  logic                   armed;

  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sh_nxt;
  logic             start;

  // cs reset-high would fake a falling edge if the pin is low at
  // reset release; only arm once real pin data shows cs high.
  assign start = (state == IDLE) & cs_fall & armed;

  // Bit shift happens before frame evaluation so a final sclk
  // edge coinciding with cs release still counts.
  always_comb begin
    sh_nxt  = shreg;
    cnt_nxt = count;
    if (sclk_fall) begin
      sh_nxt = {shreg[WIDTH-2:0], mosi_s};
      if (count != CNT_SAT) cnt_nxt = count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      prime     <= '0;
      armed     <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      prime     <= {prime[SYNC_STAGES-2:0], 1'b1};
      if (prime[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            count <= '0;
            shreg <= '0;
          end
        end
        SHIFT: begin
          shreg <= sh_nxt;
          count <= cnt_nxt;
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cnt_nxt == CNT_FULL) begin
              rx_data  <= sh_nxt;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SAMPLER_MISO_EN
  logic [WIDTH-1:0] txsh;
  logic             miso_q;

  // The first rising edge precedes any sample; the MSB is
  // already on the line from frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txsh   <= '0;
      miso_q <= 1'b0;
    end else if (start) begin
      txsh   <= tx_data;
      miso_q <= tx_data[WIDTH-1];
    end else if (state == IDLE || cs_rise) begin
      miso_q <= 1'b0;
    end else if (sclk_rise && count != '0) begin
      txsh   <= {txsh[WIDTH-2:0], 1'b0};
      miso_q <= txsh[WIDTH-2];
    end
  end

  assign miso = miso_q;

  logic unused_sig;
  assign unused_sig = ^{sclk_s, mosi_rise, mosi_fall};
`else
  assign miso = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{sclk_s, sclk_rise, mosi_rise,
                        mosi_fall, tx_data};
`endif

endmodule

// File: tb/tb_spi_sampler.sv
// Self-checking bench for spi_sampler: vector table of frames,
// strobe scoreboard, plus reset and edge-coincidence sequences.
module tb_spi_sampler;
  import spi_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;
  logic [W-1:0] tx_data;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         busy;

  spi_sampler #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic         err;
    logic [W-1:0] data;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    int           n;
    logic [31:0]  d;
    logic         err;
    logic [W-1:0] rx;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_miso(input int i);
`ifdef SPI_SAMPLER_MISO_EN
    logic [W-1:0] t;
    t = tx_data;
    if (i < W) return t[W-1-i];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err)) begin
      if (sbq.size() == 0) begin
        chk("unexpected strobe", {30'd0, rx_valid, frame_err}, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("strobe frame_err", frame_err, e.err);
        chk("strobe rx_valid", rx_valid, !e.err);
        chk("strobe rx_data", rx_data, e.data);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({name, " strobe seen"}, sbq.size(), 0);
  endtask

  task automatic frame(input logic [31:0] d, input int n,
                       input logic err, input logic [W-1:0] rx,
                       input bit simul);
    exp_t e;
    cs = 1'b0;
    wait_clk(4);
    chk("busy in frame", busy, 1);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      mosi = d[n-1-i];
      wait_clk(4);
      chk("miso bit", miso, exp_miso(i));
      e.err  = err;
      e.data = rx;
      if (simul && i == n - 1) begin
        sbq.push_back(e);
        sclk = 1'b0;
        cs   = 1'b1;
        wait_clk(2);
        chk("latency early", rx_valid, 0);
        wait_clk(1);
        chk("latency strobe", rx_valid, 1);
      end else begin
        sclk = 1'b0;
        wait_clk(4);
      end
    end
    if (!simul) begin
      e.err  = err;
      e.data = rx;
      sbq.push_back(e);
      cs = 1'b1;
    end
    mosi = 1'b0;
    drain("frame");
    wait_clk(4);
    chk("busy after frame", busy, 0);
    chk("rx_data held", rx_data, rx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    sclk    = 1'b0;
    cs      = 1'b1;
    mosi    = 1'b0;
    tx_data = 8'hC3;

    vt[0] = '{8,  32'h0000_00A5, 1'b0, 8'hA5};
    vt[1] = '{7,  32'h0000_005A, 1'b1, 8'hA5};
    vt[2] = '{9,  32'h0000_01A5, 1'b1, 8'hA5};
    vt[3] = '{24, 32'h00AB_CDA5, 1'b1, 8'hA5};
    vt[4] = '{0,  32'h0000_0000, 1'b1, 8'hA5};
    vt[5] = '{8,  32'h0000_005A, 1'b0, 8'h5A};
    vt[6] = '{8,  32'h0000_0000, 1'b0, 8'h00};
    vt[7] = '{8,  32'h0000_00FF, 1'b0, 8'hFF};

    wait_clk(3);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    chk("reset miso", miso, 0);
    rst_n = 1'b1;
    wait_clk(6);

    foreach (vt[k]) begin
      frame(vt[k].d, vt[k].n, vt[k].err, vt[k].rx, 1'b0);
    end

    // last falling sclk edge and cs release on the same clk
    frame(32'h96, 8, 1'b0, 8'h96, 1'b1);

    // reset mid-frame with cs held low
    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1;
      mosi = i[0];
      wait_clk(4);
      sclk = 1'b0;
      wait_clk(4);
    end
    rst_n = 1'b0;
    sbq.delete();
    wait_clk(2);
    chk("midreset rx_data", rx_data, 0);
    chk("midreset busy", busy, 0);
    chk("midreset rx_valid", rx_valid, 0);
    chk("midreset frame_err", frame_err, 0);
    chk("midreset miso", miso, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1;
      mosi = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
      wait_clk(4);
    end
    chk("cs low at release busy", busy, 0);
    cs   = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
    chk("after release rx_data", rx_data, 0);
    chk("after release busy", busy, 0);

    frame(32'h3C, 8, 1'b0, 8'h3C, 1'b0);

    wait_clk(10);
    chk("scoreboard empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spi_sampler.md
Name: spi_sampler

Overview:
- System-clock front end for the host SPI link; sits directly upstream of the control-register latch and the peripheral SCLK mux.
- Oversamples SCLK, CS and MOSI in the XTALCLK domain, then deserialises one frame per CS assertion.
- Emits a single-cycle strobe with the completed word, so the register stage runs in one clock domain instead of on SCLK and CS edges.
- Rejects frames whose bit count is not exactly WIDTH, and can shift readback data out on MISO.

Parameters:
- WIDTH, 8, bits per valid frame, MSB first.
- SYNC_STAGES, 2, flip-flop stages per input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock (XTALCLK); must be at least 4x the SCLK frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  raw SPI clock from the host; idles low.
- cs  in  1  raw SPI chip select, active low.
- mosi  in  1  raw SPI data in.
- miso  out  1  SPI data out (see Optional Feature).
- tx_data  in  WIDTH  readback word, sampled at frame start.
- rx_data  out  WIDTH  last valid received word; held between frames.
- rx_valid  out  1  one-cycle strobe: rx_data updated this cycle.
- frame_err  out  1  one-cycle strobe: frame ended with bit count != WIDTH.
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, miso=0, busy=0, state=IDLE, count=0, shift register=0. Synchroniser flops reset high for cs and low for sclk/mosi.
- Synchronisers: sclk, cs and mosi each pass through SYNC_STAGES flops, plus one history flop for edge detect.
  - cs_fall/cs_rise and sclk_rise/sclk_fall are single-cycle pulses derived from the synchronised values.
- SPI mode 1: MOSI is captured on the synchronised SCLK falling edge; MISO is updated on the SCLK rising edge.
- FSM states:
  - IDLE: busy=0. On cs_fall: count<=0, shreg<=0, load tx_data into the tx shift register, go to SHIFT. A cs that is already low at reset release is ignored until a full cs high-then-low transition occurs.
  - SHIFT: busy=1.
    - On sclk_fall: shreg<={shreg[WIDTH-2:0], mosi_s}; count increments and saturates at WIDTH+1.
    - On cs_rise: go to IDLE and evaluate the frame. If count==WIDTH: rx_data<=shreg and rx_valid=1 for one cycle. Otherwise frame_err=1 for one cycle and rx_data is unchanged.
- Count width: clog2(WIDTH+2). Saturation guarantees that overlong frames (e.g. 24 bits into WIDTH=8) are reported as errors, not wrapped into a false match.
- Simultaneous sclk_fall and cs_rise in the same cycle: the bit is shifted and counted first, and the frame is evaluated on the updated count and shreg.
- cs_fall while in SHIFT cannot occur without an intervening cs_rise. Edge pulses are mutually exclusive per signal.
- Latency: rx_valid asserts SYNC_STAGES+1 clk cycles after the CS rising edge at the pin.
- Zero-length frame (cs low then high, no SCLK): frame_err.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values; no strobe is emitted.

Optional Feature:
- Macro: SPI_SAMPLER_MISO_EN.
- Defined:
  - tx_data[WIDTH-1] is presented on miso at SHIFT entry.
  - On each sclk_rise after the first sclk_fall, the tx shift register shifts left and miso takes the new MSB.
  - miso is forced to 0 in IDLE.
- Undefined: miso is tied to 0, and the tx shift register and tx_data are unused and optimised away.

Decomposition:
- Shared package spi_pkg:
  - SPI_WIDTH default (8).
  - SYNC_STAGES default (2).
  - State encoding typedef: IDLE=0, SHIFT=1.
- Sub-module: sync_edge, one instance per input. It contains the SYNC_STAGES synchroniser plus history flop and outputs the synchronised level, rise pulse and fall pulse. It is reused by later SPI-facing blocks.

Test Plan:
- 8-bit frame 0xA5, SCLK at clk/8 -> exactly one rx_valid pulse; rx_data==0xA5; frame_err never asserts.
- 7-bit frame, then 9-bit frame -> one frame_err pulse each; rx_data keeps the prior 0xA5; no rx_valid.
- 24-bit frame (count saturates) -> frame_err; rx_data unchanged.
- CS released in the same clk cycle as the final SCLK falling edge (8th bit) -> rx_valid with the correct word.
- rst_n pulsed low after 4 bits of a frame with CS held low -> outputs reset; no strobe while CS remains low. The following clean 0x3C frame -> rx_valid, rx_data==0x3C.
- With SPI_SAMPLER_MISO_EN and tx_data=0xC3 -> host samples 1,1,0,0,0,0,1,1 on MISO. Without the macro -> miso constant 0.
